// File: rtl/mips_program_loader.sv
// Program loader for the MIPS-Lite pipeline core.
// Streams a host word image into the shared instruction/data memory, holds
// the core in reset for RESET_HOLD cycles, releases it, and then counts the
// run length until the core signals halt.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle pulse; begins a (re)load from IDLE/HALTED
//   in_valid/in_ready     host word handshake (in_ready high only in LOAD)
//   in_data, in_last      program word, final-word marker
//   mem_we/addr/wdata     registered one-cycle word write to memory
//   core_reset            reset to the pipeline core
//   core_halt             halt from the core writeback stage (used in RUN)
//   busy/load_done/halted/error  state flags
//   words_loaded          accepted words in the current image (saturating)
//   run_cycles            cycles spent in RUN (saturating)
module mips_program_loader #(
    parameter int unsigned ADDRESSWIDTH = 32,
    parameter int unsigned DATA         = 32,
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned RESET_HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA-1:0]         in_data,
    input  logic                    in_last,
    output logic                    mem_we,
    output logic [ADDRESSWIDTH-1:0] mem_addr,
    output logic [DATA-1:0]         mem_wdata,
    output logic                    core_reset,
    input  logic                    core_halt,
    output logic                    busy,
    output logic                    load_done,
    output logic                    halted,
    output logic                    error,
    output logic [31:0]             words_loaded,
    output logic [31:0]             run_cycles
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HOLD   = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]        words_q, words_d;
    logic [CNT_W-1:0]        run_q, run_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDRESSWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA-1:0]         mem_wdata_q, mem_wdata_d;
    logic                    core_reset_q, core_reset_d;
    logic                    busy_q, busy_d;
    logic                    load_done_q, load_done_d;
    logic                    halted_q, halted_d;
    logic                    error_q, error_d;

    logic                    hs;
    logic [ADDRESSWIDTH-1:0] ptr_inc;
    logic                    restart;

    // Handshake is a decode of the state register plus host valid.
    assign in_ready = (state_q == S_LOAD);
    assign hs       = in_valid && in_ready;
    assign ptr_inc  = ptr_q + ADDRESSWIDTH'(4);
    assign restart  = start && (state_q == S_IDLE || state_q == S_HALTED);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            hold_q       <= '0;
            words_q      <= '0;
            run_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            halted_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            words_q      <= words_d;
            run_q        <= run_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            halted_q     <= halted_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (hs) begin
                    // in_last wins over the end-of-memory check.
                    if (in_last)
                        state_d = S_HOLD;
                    else if (ptr_inc == ADDRESSWIDTH'(MEM_BYTES))
                        state_d = S_ERR;
                end
            end
            S_HOLD:   if (hold_q == HOLD_W'(RESET_HOLD - 1)) state_d = S_RUN;
            S_RUN:    if (core_halt) state_d = S_HALTED;
            S_HALTED: if (start) state_d = S_LOAD;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered output flags (flags follow the next state).
    always_comb begin
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        words_d     = words_q;
        run_d       = run_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (restart) begin
            ptr_d   = '0;
            hold_d  = '0;
            words_d = '0;
            run_d   = '0;
        end

        if (hs) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = in_data;
            ptr_d       = ptr_inc;
            words_d     = (words_q == '1) ? words_q : words_q + CNT_W'(1);
            hold_d      = '0;
        end

        if (state_q == S_HOLD)
            hold_d = hold_q + HOLD_W'(1);

        if (state_q == S_RUN)
            run_d = (run_q == '1) ? run_q : run_q + CNT_W'(1);

        core_reset_d = !(state_d == S_RUN || state_d == S_HALTED);
        busy_d       = (state_d == S_LOAD || state_d == S_HOLD);
        load_done_d  = (state_d == S_RUN || state_d == S_HALTED);
        halted_d     = (state_d == S_HALTED);
        error_d      = (state_d == S_ERR);
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign halted       = halted_q;
    assign error        = error_q;
    assign words_loaded = words_q;
    assign run_cycles   = run_q;

endmodule

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Upstream of the MIPS-Lite pipeline core: streams a program image from a host word source into the shared instruction/data memory, then holds the core in reset for a fixed settle period before releasing it.
- Monitors the core halt signal afterwards and reports the run length in clock cycles and the number of words loaded.
- Replaces ad-hoc memory preloading in the bench, so the same image path serves both the no-forwarding and forwarding pipelines.

Parameters:
- ADDRESSWIDTH, 32, width of the memory byte address.
- DATA, 32, width of the instruction/data word.
- MEM_BYTES, 4096, memory size in bytes; must be a multiple of 4.
- RESET_HOLD, 4, number of cycles core_reset stays high after the last word is loaded (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load
- in_valid  in  1  host word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  DATA  program word
- in_last  in  1  marks the final word of the image
- mem_we  out  1  memory word-write strobe
- mem_addr  out  ADDRESSWIDTH  byte address of the write (word aligned)
- mem_wdata  out  DATA  word written, big-endian across 4 bytes
- core_reset  out  1  reset to the pipeline core
- core_halt  in  1  halt signal from the core writeback stage
- busy  out  1  high in LOAD or HOLD
- load_done  out  1  high in RUN or HALTED
- halted  out  1  high in HALTED
- error  out  1  high in ERR
- words_loaded  out  32  number of accepted words in the current image
- run_cycles  out  32  cycles spent in RUN

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, HALTED, ERR. Encoding is free.
- Reset (any state, including mid-load or mid-run) forces the following on the next edge:
  - state IDLE
  - core_reset=1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - words_loaded=0, run_cycles=0
  - all flags 0
- IDLE:
  - Outputs: in_ready=0, core_reset=1.
  - start → LOAD; clear the write pointer, words_loaded and run_cycles.
- LOAD:
  - in_ready=1 combinationally while in LOAD. The handshake is in_valid & in_ready.
  - On a handshake the write is registered: the next cycle has mem_we=1, mem_addr=pointer, mem_wdata=in_data, for exactly one cycle. Back-to-back handshakes produce back-to-back writes.
  - The pointer advances by 4 and words_loaded increments on each handshake.
  - Handshake with in_last=1 → HOLD; the final write still issues in the first HOLD cycle.
  - Handshake without in_last where pointer+4 == MEM_BYTES → ERR; the write still issues.
  - A handshake with in_last=1 at the last address → HOLD, not ERR.
  - start during LOAD is ignored.
- HOLD:
  - Outputs: in_ready=0, core_reset=1.
  - Counts exactly RESET_HOLD cycles, then → RUN.
- RUN:
  - Outputs: core_reset=0; run_cycles increments every RUN cycle.
  - core_halt=1 → HALTED. The cycle in which halt is sampled is counted.
  - core_halt is ignored in every other state.
- HALTED:
  - Outputs: core_reset=0, so the core keeps its final architectural state for end-of-test dumps.
  - run_cycles and words_loaded are frozen.
  - start → LOAD (reload), with counters cleared.
- ERR:
  - Outputs: core_reset=1, error=1, in_ready=0.
  - start is ignored; only reset exits.
- Counters saturate at 2^32−1. They do not wrap.
- mem_addr is always a multiple of 4.

Test Plan:
- Reset, start, then 3 words 0x04010005, 0x04020007, 0x44000000 (last=1) with in_valid held high:
  - writes at addresses 0, 4, 8 on consecutive cycles;
  - words_loaded=3;
  - core_reset stays high for 4 cycles after the HOLD entry, then drops.
- in_valid toggled 1,0,1,0 across 2 words:
  - exactly 2 mem_we pulses;
  - no write on idle cycles;
  - addresses 0 and 4.
- MEM_BYTES=16, 5 words with no last:
  - 4 writes to addresses 0–12;
  - error=1 after the 4th handshake;
  - the 5th word is not accepted (in_ready=0);
  - core_reset=1.
- Program loaded, core_halt asserted on the 10th RUN cycle:
  - run_cycles=10, halted=1;
  - run_cycles stays 10 for 20 further cycles;
  - core_reset stays 0.
- Reset asserted mid-LOAD after 2 words:
  - next cycle: IDLE, words_loaded=0, mem_we=0, core_reset=1;
  - a new start reloads from address 0.
- start pulsed in HALTED:
  - LOAD re-entered with counters cleared and core_reset=1;
  - start pulsed during HOLD/ERR has no effect.
